// File: rtl/arb_decode_if.sv
// Score-table write port, search request and search result bundle for arb_decode.
interface arb_decode_if #(
  parameter int W = 6
);
  logic         wr_en;
  logic [5:0]   wr_addr;
  logic [W-1:0] wr_data;
  logic         start;
  logic [W-1:0] target;
  logic         busy;
  logic         done;
  logic         found;
  logic [5:0]   idx;

  modport master (
    output wr_en, wr_addr, wr_data, start, target,
    input  busy, done, found, idx
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, target,
    output busy, done, found, idx
  );
endinterface

// File: rtl/arb_decode.sv
// Inverse of the 64-to-1 max arbiter: locates the lowest square index whose
// stored score equals a requested winning score, by ascending linear scan.
module arb_decode #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  arb_decode_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] table_q [64];
  logic [5:0]   cnt_q;
  logic [W-1:0] target_q;
  logic         found_q;
  logic [5:0]   idx_q;
  logic         shadow_vld_q;
  logic [5:0]   shadow_addr_q;
  logic [W-1:0] shadow_val_q;
  logic [W-1:0] scan_val;
  logic         hit;
  logic         last;
  logic         accept;

  assign accept = (state_q == IDLE) && bus.start;
  assign last   = (cnt_q == 6'd63);

  // A write coinciding with start commits immediately, but the search must see
  // the old entry: the overwritten value is kept aside and substituted here.
  always_comb begin
    scan_val = table_q[cnt_q];
    if (shadow_vld_q && (cnt_q == shadow_addr_q)) scan_val = shadow_val_q;
    hit = (scan_val == target_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: start only honoured in IDLE, DONE always returns to IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = SCAN;
      SCAN:    if (hit || last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; result registers drive found/idx directly
  always_comb begin
    bus.busy  = (state_q != IDLE);
    bus.done  = (state_q == DONE);
    bus.found = found_q;
    bus.idx   = idx_q;
  end

  // Score table: written only while idle, cleared by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 64; i++) table_q[i] <= '0;
    end else if (bus.wr_en && (state_q == IDLE)) begin
      table_q[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Search datapath: target latch, scan counter, result and write shadow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      target_q      <= '0;
      found_q       <= 1'b0;
      idx_q         <= '0;
      shadow_vld_q  <= 1'b0;
      shadow_addr_q <= '0;
      shadow_val_q  <= '0;
    end else begin
      if (accept) begin
        target_q      <= bus.target;
        cnt_q         <= '0;
        shadow_vld_q  <= bus.wr_en;
        shadow_addr_q <= bus.wr_addr;
        shadow_val_q  <= table_q[bus.wr_addr];
      end else if (state_q == SCAN) begin
        if (hit) begin
          idx_q   <= cnt_q;
          found_q <= 1'b1;
        end else if (last) begin
          idx_q   <= '0;
          found_q <= 1'b0;
        end else begin
          cnt_q <= cnt_q + 6'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arb_decode.sv
module tb_arb_decode;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  arb_decode_if #(.W(6)) bus ();

  arb_decode #(.W(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [5:0] addr, input logic [5:0] data);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_addr = addr;
    bus.wr_data = data;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  // mid_kind: 0 nothing, 1 re-pulse start, 2 write addr 9 <= 33 during the scan.
  // mid_found/mid_idx report the result outputs seen just before the mid action.
  task automatic do_search(input logic [5:0] tgt, input int mid_cyc, input int mid_kind,
                           input logic wr_too,
                           output int lat, output int busy_n,
                           output logic mid_found, output logic [5:0] mid_idx);
    int cyc;
    lat       = 0;
    mid_found = 1'bx;
    mid_idx   = 'x;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.target = tgt;
    if (wr_too) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = 6'd0;
      bus.wr_data = 6'd7;
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.wr_en = 1'b0;
    busy_n = bus.busy ? 1 : 0;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      if (cyc == mid_cyc) begin
        mid_found = bus.found;
        mid_idx   = bus.idx;
        if (mid_kind == 1) begin
          bus.start  = 1'b1;
          bus.target = 6'd0;
        end else if (mid_kind == 2) begin
          bus.wr_en   = 1'b1;
          bus.wr_addr = 6'd9;
          bus.wr_data = 6'd33;
        end
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      cyc++;
      if (bus.busy) busy_n++;
      if (bus.done) begin
        lat = cyc + 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    check("done_single_pulse", bus.done, 1'b0);
    check("idle_after_done", bus.busy, 1'b0);
  endtask

  initial begin
    int lat, bn, dcount;
    logic mf;
    logic [5:0] mi;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.start = 1'b0; bus.target = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_found", bus.found, 0);
    check("rst_idx", bus.idx, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // table[i] = i, target 37
    for (int i = 0; i < 64; i++) wr(6'(i), 6'(i));
    do_search(6'd37, -1, 0, 1'b0, lat, bn, mf, mi);
    check("ident_lat", lat, 39);
    check("ident_busy_cycles", bn, 39);
    check("ident_found", bus.found, 1);
    check("ident_idx", bus.idx, 37);

    // tie at 5 and 50 -> lowest index wins
    for (int i = 0; i < 64; i++) wr(6'(i), 6'd10);
    wr(6'd5, 6'd63);
    wr(6'd50, 6'd63);
    do_search(6'd63, -1, 0, 1'b0, lat, bn, mf, mi);
    check("tie_lat", lat, 7);
    check("tie_found", bus.found, 1);
    check("tie_idx", bus.idx, 5);
    repeat (4) @(posedge clk);
    #1;
    check("tie_idx_held", bus.idx, 5);

    // all zero, target 12, start re-pulsed mid-scan; old result held during scan
    for (int i = 0; i < 64; i++) wr(6'(i), 6'd0);
    do_search(6'd12, 10, 1, 1'b0, lat, bn, mf, mi);
    check("miss_lat", lat, 65);
    check("miss_found", bus.found, 0);
    check("miss_idx", bus.idx, 0);
    check("hold_found_in_scan", mf, 1);
    check("hold_idx_in_scan", mi, 5);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dcount++;
    end
    check("restart_ignored", dcount, 0);

    // write during scan is dropped
    wr(6'd9, 6'd20);
    do_search(6'd3, 5, 2, 1'b0, lat, bn, mf, mi);
    check("drop_scan_lat", lat, 65);
    do_search(6'd33, -1, 0, 1'b0, lat, bn, mf, mi);
    check("drop_new_found", bus.found, 0);
    do_search(6'd20, -1, 0, 1'b0, lat, bn, mf, mi);
    check("drop_old_found", bus.found, 1);
    check("drop_old_idx", bus.idx, 9);
    check("drop_old_lat", lat, 11);

    // reset mid-scan at cycle 20
    @(negedge clk);
    bus.start  = 1'b1;
    bus.target = 6'd63;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_found", bus.found, 0);
    check("arst_idx", bus.idx, 0);
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) dcount++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) dcount++;
    end
    check("arst_no_done", dcount, 0);
    do_search(6'd0, -1, 0, 1'b0, lat, bn, mf, mi);
    check("arst_t0_lat", lat, 2);
    check("arst_t0_found", bus.found, 1);
    check("arst_t0_idx", bus.idx, 0);
    do_search(6'd20, -1, 0, 1'b0, lat, bn, mf, mi);
    check("arst_table_clr", bus.found, 0);

    // same-cycle start + write to addr 0 (data 7)
    do_search(6'd7, -1, 0, 1'b1, lat, bn, mf, mi);
    check("same_cyc_found", bus.found, 0);
    check("same_cyc_lat", lat, 65);
    do_search(6'd7, -1, 0, 1'b0, lat, bn, mf, mi);
    check("same_cyc_rep_found", bus.found, 1);
    check("same_cyc_rep_idx", bus.idx, 0);
    check("same_cyc_rep_lat", lat, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
